// File: rtl/axi_lite_master_impl.sv
// Command-driven AXI4-Lite master: one register read or write per command, one response per command.
// Illegal operations and out-of-range register indices are answered locally without touching the bus.
module axi_lite_master_impl #(
    parameter int C_M_AXI_DATA_WIDTH  = 32,
    parameter int C_M_AXI_ADDR_WIDTH  = 5,
    parameter int NUMBER_OF_REGISTERS = 6
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    // Command / response port
    input  logic [1:0]                        cmd_operation,
    input  logic [7:0]                        cmd_register_number,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_write_data,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    output logic                              rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_read_data,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_error,
    // AXI4-Lite master
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [7:0] NUM_REGS = 8'(NUMBER_OF_REGISTERS);

    state_t                          state_q;
    logic                            cmd_ready_q;
    logic                            awvalid_q;
    logic                            wvalid_q;
    logic                            bready_q;
    logic                            arvalid_q;
    logic                            rready_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic                            rsp_valid_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_read_data_q;
    logic [1:0]                      rsp_resp_q;
    logic                            rsp_error_q;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_d;
    logic                            in_range_d;
    logic                            aw_done_d;
    logic                            w_done_d;

    // Byte address of the register; upper bits beyond the bus width are dropped.
    assign addr_d     = C_M_AXI_ADDR_WIDTH'({cmd_register_number, 2'b00});
    assign in_range_d = (cmd_register_number < NUM_REGS);
    // A channel is finished once its VALID has already dropped or it handshakes now.
    assign aw_done_d  = !awvalid_q || M_AXI_AWREADY;
    assign w_done_d   = !wvalid_q  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q         <= IDLE;
            cmd_ready_q     <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awaddr_q        <= '0;
            araddr_q        <= '0;
            wdata_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_read_data_q <= '0;
            rsp_resp_q      <= 2'b00;
            rsp_error_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        awaddr_q    <= addr_d;
                        araddr_q    <= addr_d;
                        wdata_q     <= cmd_write_data;
                        if (cmd_operation == OP_WRITE && in_range_d) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_ADDR_DATA;
                        end else if (cmd_operation == OP_READ && in_range_d) begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_ADDR;
                        end else begin
                            rsp_valid_q     <= 1'b1;
                            rsp_error_q     <= 1'b1;
                            rsp_resp_q      <= 2'b00;
                            rsp_read_data_q <= '0;
                            state_q         <= DONE;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WR_ADDR_DATA: begin
                    if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (wvalid_q && M_AXI_WREADY)   wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        bready_q        <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_resp_q      <= M_AXI_BRESP;
                        rsp_error_q     <= M_AXI_BRESP[1];
                        rsp_read_data_q <= '0;
                        state_q         <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rready_q        <= 1'b0;
                        rsp_valid_q     <= 1'b1;
                        rsp_resp_q      <= M_AXI_RRESP;
                        rsp_error_q     <= M_AXI_RRESP[1];
                        rsp_read_data_q <= M_AXI_RDATA;
                        state_q         <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_read_data = rsp_read_data_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_error     = rsp_error_q;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
